// File: rtl/first_stage_pkg.sv
// Shared Q7.8 word types, product width and saturation limits for the first-stage MAC.
package first_stage_pkg;

  localparam int unsigned Q_W    = 16;
  localparam int unsigned PROD_W = 32;

  typedef logic signed [Q_W-1:0] q78_t;

  localparam q78_t SAT_MAX = 16'sh7FFF;
  localparam q78_t SAT_MIN = 16'sh8000;

endpackage

// File: rtl/first_stage_mac_pipe.sv
// S2/S3 of the first-stage MAC: registered signed product, then accumulate over ELEMENTS terms.
module first_stage_mac_pipe
  import first_stage_pkg::*;
#(
  parameter int unsigned ELEMENTS = 16,
  parameter int unsigned ACC_W    = 40
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    en,
  input  logic                    s1_valid,
  input  q78_t                    s1_a,
  input  q78_t                    s1_b,
  output logic signed [ACC_W-1:0] acc,
  output logic                    sum_done,
  output logic                    pipe_busy_c
);

  localparam int unsigned CNT_W = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
  localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(ELEMENTS - 1);

  logic signed [PROD_W-1:0] prod;
  logic                     s2_valid;
  logic [CNT_W-1:0]         elem_cnt;
  logic signed [ACC_W-1:0]  prod_ext;

  assign prod_ext    = ACC_W'(prod);
  assign pipe_busy_c = s2_valid | (elem_cnt != '0);

  // S2: product register
  always_ff @(posedge clock) begin
    if (!clear) begin
      prod     <= '0;
      s2_valid <= 1'b0;
    end else if (en) begin
      prod     <= PROD_W'(s1_a) * PROD_W'(s1_b);
      s2_valid <= s1_valid;
    end
  end

  // S3: first element loads, later elements add; sum_done is a one-cycle strobe even under stall
  always_ff @(posedge clock) begin
    if (!clear) begin
      acc      <= '0;
      elem_cnt <= '0;
      sum_done <= 1'b0;
    end else begin
      sum_done <= en && s2_valid && (elem_cnt == LAST_ELEM);
      if (en && s2_valid) begin
        acc      <= (elem_cnt == '0) ? prod_ext : acc + prod_ext;
        elem_cnt <= (elem_cnt == LAST_ELEM) ? '0 : elem_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/first_stage_mac_accumulator.sv
// First-stage MAC: operand delay line, S1 sample, MAC pipe, S4 rescale/saturate, valid/ready output.
// Define FIRST_STAGE_RELU_EN to clamp negative results to zero.
module first_stage_mac_accumulator
  import first_stage_pkg::*;
#(
  parameter int unsigned ELEMENTS    = 16,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned FRAC_BITS   = 8,
  parameter int unsigned ACC_W       = 40
) (
  input  logic           clock,
  input  logic           clear,
  input  logic           en,
  input  logic           input_address_ready,
  input  logic [Q_W-1:0] input_data,
  input  logic [Q_W-1:0] b_element,
  output logic [Q_W-1:0] result,
  output logic           result_valid,
  input  logic           result_ready,
  output logic [9:0]     result_index,
  output logic           overrun,
  output logic           busy
);

  localparam int unsigned IDX_W = 10;
  localparam logic signed [ACC_W-1:0] MAX_EXT = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] MIN_EXT = ACC_W'(SAT_MIN);

  logic [MEM_LATENCY-1:0]  addr_dly;
  logic [MEM_LATENCY:0]    addr_dly_in;
  logic                    s1_valid;
  q78_t                    s1_a;
  q78_t                    s1_b;
  logic signed [ACC_W-1:0] acc;
  logic                    sum_done;
  logic                    pipe_busy_c;

  assign addr_dly_in = {addr_dly, input_address_ready};

  // Ready pulses travel alongside the memory read; operands are sampled at the tap
  always_ff @(posedge clock) begin
    if (!clear) begin
      addr_dly <= '0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (en) begin
      addr_dly <= addr_dly_in[MEM_LATENCY-1:0];
      s1_valid <= addr_dly[MEM_LATENCY-1];
      s1_a     <= q78_t'(input_data);
      s1_b     <= q78_t'(b_element);
    end
  end

  first_stage_mac_pipe #(
    .ELEMENTS (ELEMENTS),
    .ACC_W    (ACC_W)
  ) u_pipe (
    .clock       (clock),
    .clear       (clear),
    .en          (en),
    .s1_valid    (s1_valid),
    .s1_a        (s1_a),
    .s1_b        (s1_b),
    .acc         (acc),
    .sum_done    (sum_done),
    .pipe_busy_c (pipe_busy_c)
  );

  assign busy = (|addr_dly) | s1_valid | pipe_busy_c;

  logic signed [ACC_W-1:0] scaled;
  q78_t                    sat_val;
  q78_t                    out_val;

  // S4: floor-rescale back to Q7.8 and clamp to the 16-bit range
  always_comb begin
    scaled  = acc >>> FRAC_BITS;
    sat_val = q78_t'(scaled[Q_W-1:0]);
    if (scaled > MAX_EXT) begin
      sat_val = SAT_MAX;
    end else if (scaled < MIN_EXT) begin
      sat_val = SAT_MIN;
    end
`ifdef FIRST_STAGE_RELU_EN
    out_val = sat_val[Q_W-1] ? q78_t'(0) : sat_val;
`else
    out_val = sat_val;
`endif
  end

  logic             accept;
  logic             load_sum;
  logic [Q_W-1:0]   result_n;
  logic             valid_n;
  logic [IDX_W-1:0] index_n;
  logic             overrun_n;

  // Output handshake: a completed sum loads unless an unconsumed result is being held
  always_comb begin
    accept    = result_valid && result_ready;
    load_sum  = sum_done && (!result_valid || result_ready);
    result_n  = result;
    valid_n   = result_valid;
    index_n   = result_index;
    overrun_n = overrun;
    if (accept) begin
      valid_n = 1'b0;
      index_n = result_index + IDX_W'(1);
    end
    if (load_sum) begin
      result_n = out_val;
      valid_n  = 1'b1;
    end
    if (sum_done && !load_sum) begin
      overrun_n = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      result       <= '0;
      result_valid <= 1'b0;
      result_index <= '0;
      overrun      <= 1'b0;
    end else begin
      result       <= result_n;
      result_valid <= valid_n;
      result_index <= index_n;
      overrun      <= overrun_n;
    end
  end

endmodule

// File: tb/tb_first_stage_mac_accumulator.sv
// Bench for first_stage_mac_accumulator: directed scenarios plus randomized traffic vs. a dot-product model.
module tb_first_stage_mac_accumulator;

  localparam int unsigned ELEMENTS = 16;

  logic        clock = 1'b0;
  logic        clear;
  logic        en;
  logic        input_address_ready;
  logic [15:0] input_data;
  logic [15:0] b_element;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ready;
  logic [9:0]  result_index;
  logic        overrun;
  logic        busy;

  always #5 clock = ~clock;

  first_stage_mac_accumulator #(
    .ELEMENTS    (16),
    .MEM_LATENCY (1),
    .FRAC_BITS   (8),
    .ACC_W       (40)
  ) dut (
    .clock               (clock),
    .clear               (clear),
    .en                  (en),
    .input_address_ready (input_address_ready),
    .input_data          (input_data),
    .b_element           (b_element),
    .result              (result),
    .result_valid        (result_valid),
    .result_ready        (result_ready),
    .result_index        (result_index),
    .overrun             (overrun),
    .busy                (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain dot product, floor divide by 256, clamp to int16
  function automatic logic [15:0] ref_result(input longint s);
    longint sc;
    sc = s >>> 8;
    if (sc > 32767) sc = 32767;
    else if (sc < -32768) sc = -32768;
`ifdef FIRST_STAGE_RELU_EN
    if (sc < 0) sc = 0;
`endif
    return 16'(sc);
  endfunction

  logic [15:0] op_a, op_b, pa, pb;
  logic        hit;
  longint      m_sum;
  int          m_cnt;
  logic [15:0] exp_q[$];

  // Memory stand-in plus model: each accepted pulse returns its operands one cycle later
  always @(posedge clock) begin
    hit = 1'b0;
    if (!clear) begin
      m_sum = 0;
      m_cnt = 0;
      exp_q.delete();
    end else if (en && input_address_ready) begin
      pa = op_a;
      pb = op_b;
      hit = 1'b1;
      m_sum += longint'(shortint'(pa)) * longint'(shortint'(pb));
      m_cnt++;
      if (m_cnt == ELEMENTS) begin
        exp_q.push_back(ref_result(m_sum));
        m_sum = 0;
        m_cnt = 0;
      end
    end
    #1;
    if (hit) begin
      input_data = pa;
      b_element  = pb;
    end
  end

  bit          sb_on = 1'b0;
  logic [9:0]  exp_idx;
  logic [15:0] sb_e;
  int          sb_seen = 0;

  always @(negedge clock) begin
    if (sb_on && clear && result_valid) begin
      sb_seen++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 1, 0);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_result", result, sb_e);
      end
      check("sb_index", result_index, exp_idx);
      exp_idx++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    input_address_ready = 1'b1;
    op_a = a;
    op_b = b;
    tick();
    input_address_ready = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < n; i++) send(a, b);
  endtask

  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    while (!result_valid && cycles < 60) begin
      tick();
      cycles++;
    end
    check(tag, result_valid, 1);
  endtask

  task automatic count_valid(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (result_valid) seen++;
    end
  endtask

  int w, seen;

  initial begin
    clear = 1'b0; en = 1'b1; input_address_ready = 1'b0; result_ready = 1'b1;
    input_data = '0; b_element = '0; op_a = '0; op_b = '0;
    tick(); tick();
    clear = 1'b1;

    // Unity sum with immediate acceptance
    send_n(16, 16'h0100, 16'h0100);
    wait_valid("unity_valid", w);
    check("unity_latency", w, 4);
    check("unity_result", result, 16'h1000);
    check("unity_index0", result_index, 0);
    tick();
    check("unity_pulse_1cyc", result_valid, 0);
    check("unity_index1", result_index, 1);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) send(16'($urandom), 16'($urandom));
    clear = 1'b0;
    tick(); tick();
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_index", result_index, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    clear = 1'b1;

    // Saturation both ways
    send_n(16, 16'h7FFF, 16'h7FFF);
    wait_valid("satp_valid", w);
    check("sat_pos", result, 16'h7FFF);
    tick();
    send_n(16, 16'h7FFF, 16'h8001);
    wait_valid("satn_valid", w);
`ifdef FIRST_STAGE_RELU_EN
    check("sat_neg_relu", result, 16'h0000);
`else
    check("sat_neg", result, 16'h8000);
`endif
    tick();
    check("sat_index", result_index, 2);

    // Back-pressure across two sums
    result_ready = 1'b0;
    send_n(16, 16'h0100, 16'h0100);
    wait_valid("bp_valid", w);
    check("bp_first", result, 16'h1000);
    send_n(16, 16'h0200, 16'h0100);
    repeat (6) tick();
    check("bp_hold_result", result, 16'h1000);
    check("bp_hold_valid", result_valid, 1);
    check("bp_overrun", overrun, 1);
    check("bp_hold_index", result_index, 2);
    result_ready = 1'b1;
    tick();
    check("bp_accept_valid", result_valid, 0);
    check("bp_accept_index", result_index, 3);
    count_valid(8, seen);
    check("bp_dropped_never_shown", seen, 0);

    // Stall after element 7; pulses during the stall are ignored
    send_n(8, 16'h0100, 16'h0100);
    en = 1'b0;
    input_address_ready = 1'b1;
    op_a = 16'h7FFF; op_b = 16'h7FFF;
    repeat (5) tick();
    check("stall_busy", busy, 1);
    en = 1'b1;
    input_address_ready = 1'b0;
    send_n(8, 16'h0100, 16'h0100);
    wait_valid("stall_valid", w);
    check("stall_latency", 7 + 5 + 8 + w, 24);
    check("stall_result", result, 16'h1000);
    check("overrun_sticky", overrun, 1);
    tick();

    // Reset after element 9, then one clean sum
    send_n(10, 16'h0100, 16'h0100);
    clear = 1'b0;
    tick();
    clear = 1'b1;
    check("midrst_index", result_index, 0);
    check("midrst_overrun", overrun, 0);
    send_n(16, 16'h0100, 16'h0100);
    wait_valid("midrst_valid", w);
    check("midrst_latency", w, 4);
    check("midrst_result", result, 16'h1000);
    check("midrst_index0", result_index, 0);
    tick();
    check("midrst_index1", result_index, 1);
    count_valid(12, seen);
    check("midrst_single", seen, 0);

    // Randomized traffic against the model
    clear = 1'b0;
    tick(); tick();
    clear = 1'b1;
    exp_idx = '0;
    sb_on = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      en = ($urandom_range(0, 9) < 8);
      input_address_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) begin
        op_a = 16'($urandom);
        op_b = 16'($urandom);
      end else begin
        op_a = 16'(int'($urandom_range(0, 1023)) - 512);
        op_b = 16'(int'($urandom_range(0, 1023)) - 512);
      end
      tick();
    end
    en = 1'b1;
    input_address_ready = 1'b0;
    repeat (20) tick();
    sb_on = 1'b0;
    check("rand_drained", exp_q.size(), 0);
    check("rand_enough", (sb_seen >= 20) ? 1 : 0, 1);
    check("rand_no_overrun", overrun, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
